// File: rtl/rabbit_pkg.sv
// rtl/rabbit_pkg.sv - shared constants and state type for the Rabbit keystream XOR block
//
// Purpose: word width, words per keystream block, word-index width and the
//          buffer state enum used by rabbit_stream_xor.
package rabbit_pkg;

  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int IDX_W           = $clog2(WORDS_PER_BLOCK);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } xor_state_e;

endpackage

// File: rtl/rabbit_stream_xor.sv
// rtl/rabbit_stream_xor.sv - XORs a data stream with buffered Rabbit keystream words
//
// Purpose: holds one 128-bit keystream block (s0..s3) and XORs each accepted
//          data word with the next keystream word, in order s0, s1, s2, s3.
//          Encryption and decryption are the same operation.
// Optional feature: RABBIT_XOR_LAST_EN adds din_last/dout_last; a word marked
//          last ends the current block early and discards its unused words.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ks_valid/ks_ready, s0..s3    keystream block handshake and words
//   din_valid/din_ready, din     input data word handshake
//   dout_valid/dout_ready, dout  registered result word handshake
//   din_last, dout_last          message boundary (RABBIT_XOR_LAST_EN only)
module rabbit_stream_xor
  import rabbit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ks_valid,
  output logic              ks_ready,
  input  logic [WORD_W-1:0] s0,
  input  logic [WORD_W-1:0] s1,
  input  logic [WORD_W-1:0] s2,
  input  logic [WORD_W-1:0] s3,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [WORD_W-1:0] din,
`ifdef RABBIT_XOR_LAST_EN
  input  logic              din_last,
  output logic              dout_last,
`endif
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [WORD_W-1:0] dout
);

  xor_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] ks_q, ks_d;
  logic [WORD_W-1:0] dout_q, dout_d;
  logic dout_valid_q, dout_valid_d;
  logic last_q, last_d;

  logic last_in;
  logic din_acc;
  logic blk_done;
  logic ks_acc;

`ifdef RABBIT_XOR_LAST_EN
  assign last_in   = din_last;
  assign dout_last = last_q;
`else
  assign last_in   = 1'b0;
`endif

  // The output register may take a new word when empty or draining this cycle.
  assign din_ready = (state_q == ST_LOADED) && (!dout_valid_q || dout_ready);
  assign din_acc   = din_valid && din_ready;

  // The block is used up by this accept; a new one may be taken in the same
  // cycle so a back-to-back stream never sees a bubble.
  assign blk_done  = din_acc && ((idx_q == IDX_LAST) || last_in);
  assign ks_ready  = (state_q == ST_EMPTY) || blk_done;
  assign ks_acc    = ks_valid && ks_ready;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ks_d         = ks_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    last_d       = last_q;

    if (ks_acc) begin
      state_d = ST_LOADED;
      idx_d   = '0;
      ks_d    = {s3, s2, s1, s0};
    end else if (blk_done) begin
      state_d = ST_EMPTY;
      idx_d   = '0;
    end else if (din_acc) begin
      idx_d = idx_q + IDX_W'(1);
    end

    if (din_acc) begin
      dout_d       = din ^ ks_q[idx_q];
      dout_valid_d = 1'b1;
      last_d       = last_in;
    end else if (dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      idx_q        <= '0;
      ks_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ks_q         <= ks_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      last_q       <= last_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule
